// File: rtl/gpr_pkg.sv
// Shared widths, constants and state encoding for the GPR writeback arbiter.
package gpr_pkg;
   localparam int GPR_AW = 5;
   localparam int GPR_DW = 32;

   localparam logic [GPR_AW-1:0] ZERO_REG = 5'd0;

   typedef enum logic {
      NORM    = 1'b0,
      FORCE_B = 1'b1
   } wb_state_e;
endpackage

// File: rtl/wb_starve_ctr.sv
// Saturating count of consecutive blocked B cycles; raises force_b for one
// cycle once B has been blocked MAX_WAIT times in a row.
module wb_starve_ctr
   import gpr_pkg::*;
#(
   parameter int MAX_WAIT = 4,
   parameter int WCNT_W   = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic b_valid,
   input  logic b_blocked,
   input  logic b_xfer,
   output logic force_b
);
   localparam logic [WCNT_W-1:0] CNT_CAP  = WCNT_W'(MAX_WAIT);
   localparam logic [WCNT_W-1:0] CNT_LAST = WCNT_W'(MAX_WAIT - 1);

   wb_state_e         state_q, state_d;
   logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= NORM;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         NORM:    if (b_blocked && wait_cnt_q == CNT_LAST) state_d = FORCE_B;
         FORCE_B: state_d = NORM;
         default: state_d = NORM;
      endcase
   end

   // The forced grant itself resets the wait, whether or not B showed up.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (state_q == FORCE_B || !b_valid || b_xfer)
         wait_cnt_d = '0;
      else if (b_blocked && wait_cnt_q != CNT_CAP)
         wait_cnt_d = wait_cnt_q + 1'b1;
   end

   always_comb begin
      force_b = (state_q == FORCE_B);
   end
endmodule

// File: rtl/gpr_wb_arbiter.sv
// Two-requester arbiter for the single register-file write port: A has
// priority, B gets a forced slot after MAX_WAIT blocked cycles.
module gpr_wb_arbiter
   import gpr_pkg::*;
#(
   parameter int MAX_WAIT = 4,
   parameter int WCNT_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   input  logic [GPR_AW-1:0] a_addr,
   input  logic [GPR_DW-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [GPR_AW-1:0] b_addr,
   input  logic [GPR_DW-1:0] b_data,
   output logic              b_ready,
   output logic              b_drop,
   output logic              gpr_we,
   output logic [GPR_AW-1:0] gpr_waddr,
   output logic [GPR_DW-1:0] gpr_wdata
);
   logic              force_b;
   logic              a_xfer, b_xfer, b_blocked;
   logic [GPR_AW-1:0] sel_addr;
   logic [GPR_DW-1:0] sel_data;

   logic              gpr_we_q, gpr_we_d;
   logic [GPR_AW-1:0] gpr_waddr_q, gpr_waddr_d;
   logic [GPR_DW-1:0] gpr_wdata_q, gpr_wdata_d;
   logic              b_drop_q, b_drop_d;

   wb_starve_ctr #(
      .MAX_WAIT (MAX_WAIT),
      .WCNT_W   (WCNT_W)
   ) u_starve (
      .clk       (clk),
      .rst       (rst),
      .b_valid   (b_valid),
      .b_blocked (b_blocked),
      .b_xfer    (b_xfer),
      .force_b   (force_b)
   );

   // A same-address B is stale once A writes, so it is accepted and dropped.
   always_comb begin
      a_ready   = !force_b;
      b_ready   = force_b || !a_valid || (a_valid && b_valid && a_addr == b_addr);
      a_xfer    = a_valid && a_ready;
      b_xfer    = b_valid && b_ready;
      b_blocked = !force_b && b_valid && !b_ready;
   end

   always_comb begin
      sel_addr    = a_xfer ? a_addr : b_addr;
      sel_data    = a_xfer ? a_data : b_data;
      gpr_we_d    = (a_xfer || b_xfer) && sel_addr != ZERO_REG;
      gpr_waddr_d = gpr_we_d ? sel_addr : gpr_waddr_q;
      gpr_wdata_d = gpr_we_d ? sel_data : gpr_wdata_q;
      b_drop_d    = a_xfer && b_xfer;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gpr_we_q    <= 1'b0;
         gpr_waddr_q <= '0;
         gpr_wdata_q <= '0;
         b_drop_q    <= 1'b0;
      end else begin
         gpr_we_q    <= gpr_we_d;
         gpr_waddr_q <= gpr_waddr_d;
         gpr_wdata_q <= gpr_wdata_d;
         b_drop_q    <= b_drop_d;
      end
   end

   assign gpr_we    = gpr_we_q;
   assign gpr_waddr = gpr_waddr_q;
   assign gpr_wdata = gpr_wdata_q;
   assign b_drop    = b_drop_q;
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: reset, single requesters, starvation,
// same-address drop, register zero and reset during a forced B grant.
module tb_gpr_wb_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        a_valid, b_valid;
   logic [4:0]  a_addr, b_addr;
   logic [31:0] a_data, b_data;
   logic        a_ready, b_ready, b_drop, gpr_we;
   logic [4:0]  gpr_waddr;
   logic [31:0] gpr_wdata;

   int nvec = 0;
   int nerr = 0;

   gpr_wb_arbiter #(.MAX_WAIT(4), .WCNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .a_valid   (a_valid),
      .a_addr    (a_addr),
      .a_data    (a_data),
      .a_ready   (a_ready),
      .b_valid   (b_valid),
      .b_addr    (b_addr),
      .b_data    (b_data),
      .b_ready   (b_ready),
      .b_drop    (b_drop),
      .gpr_we    (gpr_we),
      .gpr_waddr (gpr_waddr),
      .gpr_wdata (gpr_wdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      a_valid = 1'b0; a_addr = '0; a_data = '0;
      b_valid = 1'b0; b_addr = '0; b_data = '0;
      #12;
      chk("rst_we",      32'(gpr_we),    0);
      chk("rst_waddr",   32'(gpr_waddr), 0);
      chk("rst_wdata",   gpr_wdata,      0);
      chk("rst_bdrop",   32'(b_drop),    0);
      chk("rst_a_ready", 32'(a_ready),   1);
      chk("rst_b_ready", 32'(b_ready),   1);
      tick();
      rst = 1'b1;
      tick();

      // A only
      a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hDEADBEEF;
      #1 chk("a_only_ready", 32'(a_ready), 1);
      tick();
      a_valid = 1'b0;
      chk("a_only_we",    32'(gpr_we),    1);
      chk("a_only_waddr", 32'(gpr_waddr), 3);
      chk("a_only_wdata", gpr_wdata,      32'hDEADBEEF);
      tick();
      chk("a_only_we_off", 32'(gpr_we),   0);
      chk("a_only_hold",   32'(gpr_waddr), 3);

      // B only
      b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h12345678;
      #1 chk("b_only_ready", 32'(b_ready), 1);
      tick();
      b_valid = 1'b0;
      chk("b_only_we",    32'(gpr_we),    1);
      chk("b_only_waddr", 32'(gpr_waddr), 7);
      chk("b_only_wdata", gpr_wdata,      32'h12345678);

      // Starvation: four blocked cycles, then a forced B slot
      b_valid = 1'b1; b_addr = 5'd9; b_data = 32'hA5A5A5A5;
      for (int i = 0; i < 4; i++) begin
         a_valid = 1'b1; a_addr = 5'(i + 1); a_data = 32'h100 + 32'(i);
         #1;
         chk("starve_b_blocked", 32'(b_ready), 0);
         chk("starve_a_ready",   32'(a_ready), 1);
         tick();
         chk("starve_a_waddr", 32'(gpr_waddr), 32'(i + 1));
      end
      a_addr = 5'd5; a_data = 32'h105;
      #1;
      chk("force_a_ready", 32'(a_ready), 0);
      chk("force_b_ready", 32'(b_ready), 1);
      tick();
      b_valid = 1'b0;
      chk("force_we",    32'(gpr_we),    1);
      chk("force_waddr", 32'(gpr_waddr), 9);
      chk("force_wdata", gpr_wdata,      32'hA5A5A5A5);
      #1 chk("resume_a_ready", 32'(a_ready), 1);
      tick();
      a_valid = 1'b0;
      chk("resume_waddr", 32'(gpr_waddr), 5);
      chk("resume_wdata", gpr_wdata,      32'h105);

      // Wait count clears when B withdraws: 2 blocked, gap, 3 blocked, no force
      a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h1;
      b_addr = 5'd2; b_data = 32'h2;
      for (int i = 0; i < 6; i++) begin
         b_valid = (i != 2);
         #1 chk("clear_a_ready", 32'(a_ready), 1);
         tick();
      end
      a_valid = 1'b0; b_valid = 1'b0;
      tick();

      // Same-address collision: A wins, B dropped
      a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1;
      b_valid = 1'b1; b_addr = 5'd5; b_data = 32'h2;
      #1;
      chk("coll_a_ready", 32'(a_ready), 1);
      chk("coll_b_ready", 32'(b_ready), 1);
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      chk("coll_we",    32'(gpr_we),    1);
      chk("coll_waddr", 32'(gpr_waddr), 5);
      chk("coll_wdata", gpr_wdata,      32'h1);
      chk("coll_drop",  32'(b_drop),    1);
      tick();
      chk("coll_drop_off", 32'(b_drop), 0);
      chk("coll_we_off",   32'(gpr_we), 0);

      // Register zero from A, then from B
      a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFFFFFF;
      #1 chk("r0_a_ready", 32'(a_ready), 1);
      tick();
      a_valid = 1'b0;
      chk("r0_a_we",    32'(gpr_we),    0);
      chk("r0_a_waddr", 32'(gpr_waddr), 5);
      chk("r0_a_wdata", gpr_wdata,      32'h1);
      b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h77;
      #1 chk("r0_b_ready", 32'(b_ready), 1);
      tick();
      b_valid = 1'b0;
      chk("r0_b_we",    32'(gpr_we),    0);
      chk("r0_b_wdata", gpr_wdata,      32'h1);

      // Reset while in FORCE_B
      b_valid = 1'b1; b_addr = 5'd9; b_data = 32'hCAFEF00D;
      for (int i = 0; i < 4; i++) begin
         a_valid = 1'b1; a_addr = 5'(10 + i); a_data = 32'h200 + 32'(i);
         tick();
      end
      #1;
      chk("rf_force_a_ready", 32'(a_ready), 0);
      chk("rf_pre_we",        32'(gpr_we),  1);
      #1 rst = 1'b0;
      #1;
      chk("rf_we",      32'(gpr_we),    0);
      chk("rf_waddr",   32'(gpr_waddr), 0);
      chk("rf_wdata",   gpr_wdata,      0);
      chk("rf_a_ready", 32'(a_ready),   1);
      chk("rf_b_ready", 32'(b_ready),   0);
      a_valid = 1'b0; b_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("rf_post_we",    32'(gpr_we),    0);
      tick();
      chk("rf_post_we2",   32'(gpr_we),    0);
      chk("rf_post_waddr", 32'(gpr_waddr), 0);

      // Re-presented B after reset goes through
      b_valid = 1'b1;
      #1 chk("rf_rep_ready", 32'(b_ready), 1);
      tick();
      b_valid = 1'b0;
      chk("rf_rep_waddr", 32'(gpr_waddr), 9);
      chk("rf_rep_wdata", gpr_wdata,      32'hCAFEF00D);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
